// File: rtl/regfile_dumper.sv
// regfile_dumper: walks a register-file address range through one read port
// and streams (address, data) pairs out on a valid/ready interface.
//
// Handshake: a word transfers on a rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_addr/out_data/out_last
// hold. out_valid never depends combinationally on out_ready; out_ready only
// steers the next-edge load decision.
module regfile_dumper #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [1:0]        dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic [ADDR_W:0]   remaining_q;
   logic              busy_q;
   logic              done_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic [DATA_W-1:0] out_data_q;

   // Word count is inclusive and wraps mod 2**ADDR_W, so last == first-1 is a full dump.
   logic [ADDR_W-1:0] span_d;
   logic [ADDR_W:0]   remaining_d;
   logic              load_d;
   logic              handshake_d;

   assign span_d      = last_addr - first_addr;
   assign remaining_d = {1'b0, span_d} + (ADDR_W+1)'(1);
   assign handshake_d = out_valid_q && out_ready;
   assign load_d      = (remaining_q != '0) && (!out_valid_q || out_ready);

   // Single FSM: owns range pointer, word counter and the registered output stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  ptr_q       <= first_addr;
                  remaining_q <= remaining_d;
                  busy_q      <= 1'b1;
                  state_q     <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (handshake_d && out_last_q) begin
                  // Final word accepted; counter is already zero so nothing reloads.
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= S_DONE;
               end else if (load_d) begin
                  out_data_q  <= rf_rdata;
                  out_addr_q  <= ptr_q;
                  out_valid_q <= 1'b1;
                  out_last_q  <= (remaining_q == (ADDR_W+1)'(1));
                  ptr_q       <= ptr_q + ADDR_W'(1);
                  remaining_q <= remaining_q - (ADDR_W+1)'(1);
               end else if (handshake_d) begin
                  out_valid_q <= 1'b0;
               end
            end
            S_DONE: begin
               // One-cycle done pulse; a start seen here is dropped.
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign rf_raddr    = ptr_q;
   assign out_valid   = out_valid_q;
   assign out_last    = out_last_q;
   assign out_addr    = out_addr_q;
   assign out_data    = out_data_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// Bench for regfile_dumper: register-file model, table of dump ranges,
// scoreboard queue of expected words, hand sequences for corner cases.
module tb_regfile_dumper;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic          busy, done, out_valid, out_last;
  logic          out_ready = 1'b0;
  logic [AW-1:0] rf_raddr, out_addr;
  logic [DW-1:0] rf_rdata, out_data;
  logic [1:0]    dbg_state;

  regfile_dumper #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .busy       (busy),
    .done       (done),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_last   (out_last),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // register file model, r0 hardwired to zero
  logic [DW-1:0] rf [32];
  assign rf_rdata = (rf_raddr == '0) ? '0 : rf[rf_raddr];

  int total = 0;
  int bad = 0;
  int words_seen = 0;
  int done_seen = 0;
  logic [AW+DW:0] exp_q[$];
  logic [AW+DW:0] held;
  logic           stall_pending = 1'b0;
  logic [6:0]     pat = 7'b1101001;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // scoreboard: words transfer on the next rising edge when valid && ready here
  always @(negedge clk) begin
    if (rst) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_hold", 64'({out_addr, out_data, out_last}), 64'(held));
      end
      stall_pending = out_valid && !out_ready;
      held = {out_addr, out_data, out_last};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(out_addr), 64'hFFFF);
        end else begin
          logic [AW+DW:0] item;
          item = exp_q.pop_front();
          check("word_addr", 64'(out_addr), 64'(item[AW+DW:DW+1]));
          check("word_data", 64'(out_data), 64'(item[DW:1]));
          check("word_last", 64'(out_last), 64'(item[0]));
        end
        words_seen++;
      end
      if (done) done_seen++;
    end
  end

  // driver tasks
  task automatic push_exp(input logic [AW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = first + AW'(i);
      d = (a == '0) ? '0 : rf[a];
      exp_q.push_back({a, d, (i == n - 1)});
    end
  endtask

  task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
    start = 1'b1;
    first_addr = f;
    last_addr = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream_until(input int target, input int mode, input logic chk_first,
                              input logic [AW-1:0] first);
    int cnt;
    cnt = 0;
    while (words_seen < target && cnt < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[cnt % 7];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      if (chk_first && cnt == 0) begin
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_addr", 64'(out_addr), 64'(first));
      end
      cnt++;
    end
    if (words_seen < target) check("timeout_words", 64'(words_seen), 64'(target));
  endtask

  task automatic finish_checks();
    check("done_pulse", 64'(done), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("done_low", 64'(done), 64'd0);
    check("idle_state", 64'(dbg_state), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l, input int mode,
                          input int n);
    int base;
    base = words_seen;
    push_exp(f, n);
    do_start(f, l);
    check("busy_start", 64'(busy), 64'd1);
    check("raddr_start", 64'(rf_raddr), 64'(f));
    check("valid_e0", 64'(out_valid), 64'd0);
    stream_until(base + n, mode, 1'b1, f);
    finish_checks();
  endtask

  typedef struct {
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    int            mode;  // 0 ready high, 1 fixed toggle pattern, 2 random
    int            n;     // words expected, derived by hand from the range
  } vec_t;

  vec_t vecs[7];

  initial begin
    int base, dsave;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;
    vecs[0] = '{5'd0,  5'd31, 0, 32};
    vecs[1] = '{5'd30, 5'd1,  0, 4};
    vecs[2] = '{5'd4,  5'd7,  1, 4};
    vecs[3] = '{5'd9,  5'd9,  0, 1};
    vecs[4] = '{5'd5,  5'd4,  0, 32};
    vecs[5] = '{5'd17, 5'd20, 2, 4};
    vecs[6] = '{5'd31, 5'd0,  1, 2};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_raddr", 64'(rf_raddr), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_done", 64'(done), 64'd0);
    check("idle_state0", 64'(dbg_state), 64'd0);

    for (int v = 0; v < 7; v++) begin
      run_dump(vecs[v].first, vecs[v].last, vecs[v].mode, vecs[v].n);
    end

    // ignored start during STREAM, plus a write ahead of the pointer
    base = words_seen;
    out_ready = 1'b0;
    do_start(5'd10, 5'd15);
    @(posedge clk); #1;
    do_start(5'd0, 5'd31);
    check("ign_state", 64'(dbg_state), 64'd1);
    check("ign_addr", 64'(out_addr), 64'd10);
    check("ign_raddr", 64'(rf_raddr), 64'd11);
    rf[12] = 32'hDEADBEEF;
    push_exp(5'd10, 6);
    stream_until(base + 6, 0, 1'b0, 5'd10);
    finish_checks();

    // start on the done cycle is dropped; next cycle start is taken
    base = words_seen;
    push_exp(5'd3, 1);
    do_start(5'd3, 5'd3);
    stream_until(base + 1, 0, 1'b0, 5'd3);
    check("done_cyc", 64'(done), 64'd1);
    do_start(5'd20, 5'd25);
    check("start_in_done", 64'(busy), 64'd0);
    out_ready = 1'b0;
    run_dump(5'd2, 5'd3, 0, 2);

    // reset in the middle of a dump
    base = words_seen;
    push_exp(5'd0, 32);
    do_start(5'd0, 5'd31);
    stream_until(base + 3, 0, 1'b0, 5'd0);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_outs", 64'({out_addr, out_data, out_last, done}), 64'd0);
    check("mid_rst_raddr", 64'(rf_raddr), 64'd0);
    exp_q.delete();
    dsave = done_seen;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_done_abort", 64'(done_seen), 64'(dsave));
    check("idle_after_rst", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    run_dump(5'd0, 5'd31, 2, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
